// File: rtl/sd_port_arbiter.sv
// sd_port_arbiter: shares one HPS block-device channel between two sector
// requesters (A = floppy, B = SDC hard disk). Whole-sector grants, round-robin
// on ties, watchdog release if the HPS never acknowledges. All state moves on
// the falling edge of CLK so it lines up with the SDC block.
module sd_port_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic        CLK,
    input  logic        RESET_N,

    input  logic [31:0] a_lba,
    input  logic        a_rd,
    input  logic        a_wr,
    output logic        a_ack,
    output logic        a_buff_wr,
    input  logic [7:0]  a_buff_din,

    input  logic [31:0] b_lba,
    input  logic        b_rd,
    input  logic        b_wr,
    output logic        b_ack,
    output logic        b_buff_wr,
    input  logic [7:0]  b_buff_din,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,

    output logic [1:0]  grant,
    output logic        timeout
);

    localparam int unsigned LBA_W  = 32;
    localparam int unsigned WDOG_W = 24;

    // Last watchdog count before the request is abandoned.
    localparam logic [WDOG_W-1:0] WDOG_LAST = TIMEOUT - WDOG_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_XFER     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                last_b_q;
    logic                last_b_d;
    logic [WDOG_W-1:0]   wdog_q;
    logic [WDOG_W-1:0]   wdog_d;
    logic                ack_dly_q;

    logic [LBA_W-1:0]    sd_lba_d;
    logic                sd_rd_d;
    logic                sd_wr_d;
    logic [1:0]          grant_d;
    logic                timeout_d;

    logic                req_a;
    logic                req_b;
    logic                pick_b;
    logic                win_rd;
    logic [LBA_W-1:0]    win_lba;

    // Arbitration: a lone requester wins; on a tie the port that did not go last wins.
    assign req_a   = a_rd | a_wr;
    assign req_b   = b_rd | b_wr;
    assign pick_b  = req_b & ~(req_a & last_b_q);
    assign win_rd  = pick_b ? b_rd  : a_rd;
    assign win_lba = pick_b ? b_lba : a_lba;

    // Zero-latency gating of the HPS stream to the owning port.
    assign a_ack       = sd_ack & grant[0];
    assign b_ack       = sd_ack & grant[1];
    assign a_buff_wr   = sd_buff_wr & sd_ack & grant[0];
    assign b_buff_wr   = sd_buff_wr & sd_ack & grant[1];
    assign sd_buff_din = grant[1] ? b_buff_din : a_buff_din;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        wdog_d    = wdog_q;
        sd_lba_d  = sd_lba;
        sd_rd_d   = sd_rd;
        sd_wr_d   = sd_wr;
        grant_d   = grant;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_a | req_b) begin
                    grant_d  = pick_b ? GRANT_B : GRANT_A;
                    last_b_d = pick_b;
                    sd_lba_d = win_lba;
                    // Read wins when a port raises rd and wr together.
                    sd_rd_d  = win_rd;
                    sd_wr_d  = ~win_rd;
                    wdog_d   = '0;
                    state_d  = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_XFER;
                end else if (wdog_q == WDOG_LAST) begin
                    sd_rd_d   = 1'b0;
                    sd_wr_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end

            ST_XFER: begin
                // End of sector is the falling edge of sd_ack.
                if (ack_dly_q & ~sd_ack) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                grant_d = GRANT_NONE;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, falling-edge clocked with async reset.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            wdog_q    <= '0;
            ack_dly_q <= 1'b0;
            sd_lba    <= '0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            grant     <= GRANT_NONE;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            wdog_q    <= wdog_d;
            ack_dly_q <= sd_ack;
            sd_lba    <= sd_lba_d;
            sd_rd     <= sd_rd_d;
            sd_wr     <= sd_wr_d;
            grant     <= grant_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Bench for sd_port_arbiter: directed scenarios plus randomized requesters and
// HPS, checked every cycle against a transaction-level reference model.
module tb_sd_port_arbiter;

    localparam logic [23:0] TMO = 24'd16;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [31:0] a_lba = '0, b_lba = '0;
    logic        a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic        a_ack, b_ack, a_buff_wr, b_buff_wr;
    logic [7:0]  a_buff_din = '0, b_buff_din = '0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_din;
    logic [1:0]  grant;
    logic        timeout;

    always #5 CLK = ~CLK;

    sd_port_arbiter #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .a_lba(a_lba), .a_rd(a_rd), .a_wr(a_wr), .a_ack(a_ack),
        .a_buff_wr(a_buff_wr), .a_buff_din(a_buff_din),
        .b_lba(b_lba), .b_rd(b_rd), .b_wr(b_wr), .b_ack(b_ack),
        .b_buff_wr(b_buff_wr), .b_buff_din(b_buff_din),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .grant(grant), .timeout(timeout)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 none, 1 A, 2 B. A transfer is "issued" while a strobe is up,
    // "streaming" once acked, and "releasing" for one edge before the port frees.
    logic [1:0]  m_grant;
    logic        m_rd, m_wr, m_to;
    logic [31:0] m_lba;
    int          m_last, m_waited, m_win;
    bit          m_acked, m_prev_ack, m_releasing, m_ra, m_rb;

    always @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_grant = 2'b00; m_rd = 1'b0; m_wr = 1'b0; m_to = 1'b0; m_lba = '0;
            m_last = 2; m_waited = 0; m_acked = 0; m_prev_ack = 0; m_releasing = 0;
        end else begin
            m_to = 1'b0;
            if (m_releasing) begin
                m_grant = 2'b00;
                m_releasing = 0;
            end else if (m_grant == 2'b00) begin
                m_ra = a_rd | a_wr;
                m_rb = b_rd | b_wr;
                if (m_ra || m_rb) begin
                    if (m_ra && m_rb) m_win = (m_last == 2) ? 1 : 2;
                    else              m_win = m_ra ? 1 : 2;
                    m_last   = m_win;
                    m_grant  = (m_win == 1) ? 2'b01 : 2'b10;
                    m_lba    = (m_win == 1) ? a_lba : b_lba;
                    m_rd     = (m_win == 1) ? a_rd : b_rd;
                    m_wr     = !m_rd;
                    m_waited = 0;
                end
            end else if (m_rd || m_wr) begin
                if (sd_ack) begin
                    m_rd = 1'b0; m_wr = 1'b0; m_acked = 1;
                end else if (m_waited == int'(TMO) - 1) begin
                    m_rd = 1'b0; m_wr = 1'b0; m_to = 1'b1; m_releasing = 1;
                end else begin
                    m_waited++;
                end
            end else if (m_acked && m_prev_ack && !sd_ack) begin
                m_acked = 0;
                m_releasing = 1;
            end
            m_prev_ack = sd_ack;
        end
    end

    // ---------------- per-cycle compare + observations ----------------
    int          cyc = 0;
    logic [1:0]  g_log[$];
    logic [1:0]  prev_grant = 2'b00;
    logic        prev_rd = 1'b0;
    int          pa_cnt = 0, pb_cnt = 0, t_rd = 0, to_gap = 0, to_cnt = 0;
    int          b_ack_cnt = 0, b_wr_cnt = 0;
    logic [7:0]  b_din_last = '0;

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            cyc++;
            chk("sd_rd",       32'(sd_rd),       32'(m_rd));
            chk("sd_wr",       32'(sd_wr),       32'(m_wr));
            chk("grant",       32'(grant),       32'(m_grant));
            chk("timeout",     32'(timeout),     32'(m_to));
            chk("sd_lba",      sd_lba,           m_lba);
            chk("a_ack",       32'(a_ack),       32'(sd_ack & m_grant[0]));
            chk("b_ack",       32'(b_ack),       32'(sd_ack & m_grant[1]));
            chk("a_buff_wr",   32'(a_buff_wr),   32'(sd_buff_wr & sd_ack & m_grant[0]));
            chk("b_buff_wr",   32'(b_buff_wr),   32'(sd_buff_wr & sd_ack & m_grant[1]));
            chk("sd_buff_din", 32'(sd_buff_din), 32'(m_grant[1] ? b_buff_din : a_buff_din));
            if (grant != 2'b00 && prev_grant == 2'b00) g_log.push_back(grant);
            prev_grant = grant;
            pa_cnt += int'(a_buff_wr);
            pb_cnt += int'(b_buff_wr);
            if (sd_rd && !prev_rd) t_rd = cyc;
            prev_rd = sd_rd;
            if (timeout) begin to_cnt++; to_gap = cyc - t_rd; end
            if (b_ack) b_ack_cnt++;
            if (grant == 2'b10) begin
                if (sd_wr) b_wr_cnt++;
                b_din_last = sd_buff_din;
            end
        end
    end

    // ---------------- stimulus: requesters and HPS ----------------
    bit rand_en = 0;
    bit cfg_silent = 0;
    int cfg_len = 4, cfg_delay = 1;
    int hps_st = 0, hps_cnt = 0, hps_len = 0, hps_pulses = 0;
    bit hps_sil = 0;

    // One clock of requester and HPS behaviour; returns after the compare.
    task automatic step();
        int k;
        @(posedge CLK);
        if ((a_rd | a_wr) && a_ack) begin a_rd = 1'b0; a_wr = 1'b0; end
        if ((b_rd | b_wr) && b_ack) begin b_rd = 1'b0; b_wr = 1'b0; end
        if (rand_en) begin
            if (!(a_rd | a_wr) && $urandom_range(3) == 0) begin
                k = int'($urandom_range(1, 3)); a_rd = k[0]; a_wr = k[1];
            end else if ((a_rd | a_wr) && $urandom_range(31) == 0) begin
                a_rd = 1'b0; a_wr = 1'b0;
            end
            if (!(b_rd | b_wr) && $urandom_range(3) == 0) begin
                k = int'($urandom_range(1, 3)); b_rd = k[0]; b_wr = k[1];
            end else if ((b_rd | b_wr) && $urandom_range(31) == 0) begin
                b_rd = 1'b0; b_wr = 1'b0;
            end
            a_lba = $urandom; b_lba = $urandom;
            a_buff_din = 8'($urandom); b_buff_din = 8'($urandom);
        end
        case (hps_st)
            0: if (sd_rd | sd_wr) begin
                hps_cnt = rand_en ? int'($urandom_range(6)) : cfg_delay;
                hps_len = rand_en ? int'($urandom_range(1, 6)) : cfg_len;
                hps_sil = rand_en ? ($urandom_range(7) == 0) : cfg_silent;
                hps_st  = 1;
            end
            1: if (!(sd_rd | sd_wr)) begin
                hps_st = 0;
            end else if (!hps_sil) begin
                if (hps_cnt == 0) begin
                    sd_ack = 1'b1; sd_buff_wr = 1'b0; hps_pulses = 0; hps_st = 2;
                end else begin
                    hps_cnt--;
                end
            end
            default: if (sd_buff_wr) begin
                sd_buff_wr = 1'b0;
                hps_pulses++;
                if (hps_pulses == hps_len) begin sd_ack = 1'b0; hps_st = 0; end
            end else begin
                sd_buff_wr = 1'b1;
            end
        endcase
        #3;
    endtask

    function automatic bit all_idle();
        return !(a_rd | a_wr | b_rd | b_wr) && grant == 2'b00 && hps_st == 0 && !sd_rd && !sd_wr;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = all_idle();
        end
        chk({name, "_drain_budget"}, 32'(done), 32'd1);
    endtask

    task automatic wait_grant(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (grant != 2'b00);
        end
        chk({name, "_grant_budget"}, 32'(done), 32'd1);
    endtask

    function automatic logic [1:0] glog_at(input int i);
        return (i < g_log.size()) ? g_log[i] : 2'b11;
    endfunction

    task automatic hps_reset();
        sd_ack = 1'b0; sd_buff_wr = 1'b0; hps_st = 0;
    endtask

    int gb, pa0, pb0, tc0, bk0, bw0;
    bit b_set, rereq, done;

    initial begin
        // Reset values
        #3 RESET_N = 1'b0;
        #1;
        chk("rst_sd_rd",   32'(sd_rd),   32'd0);
        chk("rst_sd_wr",   32'(sd_wr),   32'd0);
        chk("rst_grant",   32'(grant),   32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_sd_lba",  sd_lba,       32'd0);
        repeat (2) step();
        RESET_N = 1'b1;
        step();

        // Single read from A, 512 bytes
        cfg_len = 512; cfg_delay = 2;
        pa0 = pa_cnt; pb0 = pb_cnt;
        a_rd = 1'b1; a_lba = 32'h12;
        wait_grant("single", 10);
        chk("single_sd_lba", sd_lba,      32'h12);
        chk("single_sd_rd",  32'(sd_rd),  32'd1);
        chk("single_grant",  32'(grant),  32'd1);
        wait_idle("single", 2000);
        chk("single_a_bytes", 32'(pa_cnt - pa0), 32'd512);
        chk("single_b_bytes", 32'(pb_cnt - pb0), 32'd0);
        chk("single_grant_end", 32'(grant), 32'd0);

        // Simultaneous requests straight out of reset: A first, then B write
        cfg_len = 8; cfg_delay = 1;
        RESET_N = 1'b0;
        a_rd = 1'b1; b_wr = 1'b1; a_lba = 32'h100; b_lba = 32'h200;
        a_buff_din = 8'h3C; b_buff_din = 8'hA5;
        gb = g_log.size(); bw0 = b_wr_cnt;
        repeat (2) step();
        RESET_N = 1'b1;
        wait_idle("simul", 400);
        chk("simul_first",  32'(glog_at(gb)),     32'd1);
        chk("simul_second", 32'(glog_at(gb + 1)), 32'd2);
        chk("simul_b_sd_wr", 32'((b_wr_cnt > bw0) ? 1 : 0), 32'd1);
        chk("simul_b_din",  32'(b_din_last), 32'hA5);

        // Fairness: A re-requests right after release while B waits
        gb = g_log.size(); b_set = 0; rereq = 0; done = 0;
        a_rd = 1'b1; a_lba = 32'h300; b_lba = 32'h400;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (grant == 2'b01 && !b_set) begin b_rd = 1'b1; b_set = 1; end
            if (g_log.size() == gb + 1 && grant == 2'b00 && !(a_rd | a_wr) && !rereq) begin
                a_rd = 1'b1; rereq = 1;
            end
            done = (g_log.size() >= gb + 3) && all_idle();
        end
        chk("fair_budget", 32'(done), 32'd1);
        chk("fair_0", 32'(glog_at(gb)),     32'd1);
        chk("fair_1", 32'(glog_at(gb + 1)), 32'd2);
        chk("fair_2", 32'(glog_at(gb + 2)), 32'd1);

        // Watchdog: B reads, HPS stays silent
        cfg_silent = 1;
        tc0 = to_cnt; bk0 = b_ack_cnt; done = 0;
        b_rd = 1'b1; b_lba = 32'h55;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            done = timeout;
        end
        chk("to_seen",  32'(done), 32'd1);
        chk("to_gap",   32'(to_gap), 32'd16);
        chk("to_sd_rd", 32'(sd_rd), 32'd0);
        b_rd = 1'b0;
        wait_idle("to", 20);
        cfg_silent = 0;
        chk("to_pulses", 32'(to_cnt - tc0), 32'd1);
        chk("to_b_ack",  32'(b_ack_cnt - bk0), 32'd0);
        chk("to_grant",  32'(grant), 32'd0);

        // Reset in the middle of a sector
        cfg_len = 512; cfg_delay = 1; done = 0;
        a_rd = 1'b1; a_lba = 32'h66;
        for (int i = 0; i < 1000 && !done; i++) begin
            step();
            done = (hps_st == 2 && hps_pulses == 200);
        end
        chk("mid_reach", 32'(done), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("mid_sd_rd",     32'(sd_rd),     32'd0);
        chk("mid_grant",     32'(grant),     32'd0);
        chk("mid_sd_lba",    sd_lba,         32'd0);
        chk("mid_a_ack",     32'(a_ack),     32'd0);
        chk("mid_a_buff_wr", 32'(a_buff_wr), 32'd0);
        hps_reset();
        a_rd = 1'b0;
        repeat (2) step();
        RESET_N = 1'b1;
        cfg_len = 4;
        a_rd = 1'b1; a_lba = 32'h77;
        wait_grant("post_rst", 10);
        chk("post_rst_grant",  32'(grant), 32'd1);
        chk("post_rst_sd_lba", sd_lba,     32'h77);
        wait_idle("post_rst", 100);

        // Randomized traffic
        rand_en = 1;
        repeat (3000) step();
        rand_en = 0;
        wait_idle("random", 600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
